// File: rtl/apb_cmd_master_if.sv
// Command/response stream plus APB bus for apb_cmd_master.
// Handshake: a command transfers on any rising PCLK edge where cmd_valid and
// cmd_ready are both 1; cmd_write/cmd_addr/cmd_wdata must be stable while
// cmd_valid is 1 and cmd_ready is 0. rsp_valid is a one-cycle pulse with no
// backpressure.
interface apb_cmd_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;
  logic              busy;

  logic [ADDR_W-1:0] PADDR;
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLAVEERR;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  PRDATA, PREADY, PSLAVEERR,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, busy,
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output PRDATA, PREADY, PSLAVEERR,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, busy,
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA
  );
endinterface

// File: rtl/apb_cmd_master.sv
// APB master: buffers read/write commands in a small FIFO and replays them as
// APB SETUP/ACCESS transfers, returning one in-order response per command.
// Transfers stalled by PREADY=0 for TIMEOUT ACCESS cycles are aborted.
module apb_cmd_master #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  apb_cmd_master_if.master    bus,
  output logic [1:0]          state_dbg
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam int ENT_W  = 1 + ADDR_W + DATA_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t              state;
  logic [ENT_W-1:0]    mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    count;
  logic [WAIT_W-1:0]   wait_cnt;

  logic                full;
  logic                empty;
  logic                push;
  logic                pop;
  logic                complete;
  logic                abort;
  logic [ENT_W-1:0]    head;

  assign full     = (count == CNT_W'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign push     = bus.cmd_valid && !full;
  assign complete = (state == ACCESS) && bus.PREADY;
  // The TIMEOUT-th consecutive low-PREADY ACCESS cycle ends in an abort.
  assign abort    = (state == ACCESS) && !bus.PREADY &&
                    (wait_cnt == WAIT_W'(TIMEOUT - 1));
  // The head is taken whenever the FSM starts a new transfer.
  assign pop      = !empty && ((state == IDLE) || complete || abort);
  assign head     = mem[rd_ptr];

  assign bus.cmd_ready = !full;
  assign bus.busy      = !empty || (state != IDLE);
  assign state_dbg     = state;

  // FIFO storage; entries carry no reset since count gates their use.
  always_ff @(posedge PCLK) begin
    if (push) mem[wr_ptr] <= {bus.cmd_write, bus.cmd_addr, bus.cmd_wdata};
  end

  // FIFO pointers and occupancy; pointers wrap naturally (depth is 2^n).
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // APB transfer FSM with registered bus and response outputs.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state           <= IDLE;
      wait_cnt        <= '0;
      bus.PSEL        <= 1'b0;
      bus.PENABLE     <= 1'b0;
      bus.PWRITE      <= 1'b0;
      bus.PADDR       <= '0;
      bus.PWDATA      <= '0;
      bus.rsp_valid   <= 1'b0;
      bus.rsp_rdata   <= '0;
      bus.rsp_err     <= 1'b0;
      bus.rsp_timeout <= 1'b0;
    end else begin
      bus.rsp_valid   <= 1'b0;
      bus.rsp_rdata   <= '0;
      bus.rsp_err     <= 1'b0;
      bus.rsp_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            {bus.PWRITE, bus.PADDR, bus.PWDATA} <= head;
            bus.PSEL    <= 1'b1;
            bus.PENABLE <= 1'b0;
            wait_cnt    <= '0;
            state       <= SETUP;
          end
        end
        SETUP: begin
          bus.PENABLE <= 1'b1;
          state       <= ACCESS;
        end
        ACCESS: begin
          if (complete || abort) begin
            bus.rsp_valid <= 1'b1;
            if (complete) begin
              bus.rsp_err   <= bus.PSLAVEERR;
              bus.rsp_rdata <= bus.PWRITE ? '0 : bus.PRDATA;
            end else begin
              bus.rsp_err     <= 1'b1;
              bus.rsp_timeout <= 1'b1;
            end
            // Chain straight into the next SETUP so PSEL stays high.
            if (!empty) begin
              {bus.PWRITE, bus.PADDR, bus.PWDATA} <= head;
              bus.PENABLE <= 1'b0;
              wait_cnt    <= '0;
              state       <= SETUP;
            end else begin
              bus.PSEL    <= 1'b0;
              bus.PENABLE <= 1'b0;
              state       <= IDLE;
            end
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        default: begin
          bus.PSEL    <= 1'b0;
          bus.PENABLE <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master: reset, PWM programming burst, wait
// states, FIFO full with timeout abort, slave error, and reset mid-transfer.
module tb_apb_cmd_master;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic       PCLK;
  logic       PRESETn;
  logic [1:0] state_dbg;

  apb_cmd_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ifc ();

  apb_cmd_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(4), .TIMEOUT(16)
  ) dut (
    .PCLK(PCLK),
    .PRESETn(PRESETn),
    .bus(ifc),
    .state_dbg(state_dbg)
  );

  // Clock and reset
  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // Scoreboard: {timeout, err, rdata}
  logic [DATA_W+1:0] exp_q[$];
  int checks  = 0;
  int errors  = 0;
  int rsp_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W+1:0] rsp(input logic to, input logic err,
                                             input logic [DATA_W-1:0] d);
    return {to, err, d};
  endfunction

  // Drivers
  task automatic drive_cmd(input logic wr, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d);
    ifc.cmd_valid = 1'b1;
    ifc.cmd_write = wr;
    ifc.cmd_addr  = a;
    ifc.cmd_wdata = d;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (ifc.busy && n < 200) begin
      @(negedge PCLK);
      n++;
    end
    chk("idle_bound", ifc.busy, 0);
  endtask

  // Response monitor
  always @(negedge PCLK) begin
    if (PRESETn && ifc.rsp_valid) begin
      rsp_cnt++;
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", ifc.rsp_valid, 0);
      end else begin
        chk("rsp", {ifc.rsp_timeout, ifc.rsp_err, ifc.rsp_rdata}, exp_q.pop_front());
      end
    end
  end

  logic [ADDR_W-1:0] b_addr [4];
  logic [DATA_W-1:0] b_data [4];
  logic [ADDR_W-1:0] f_addr [4];
  logic              f_wr   [4];

  initial begin
    b_addr = '{32'h4, 32'h0, 32'h8, 32'hC};
    b_data = '{32'd4, 32'd8, 32'd7, 32'd1};
    f_addr = '{32'h24, 32'h28, 32'h2C, 32'h30};
    f_wr   = '{1'b1, 1'b0, 1'b1, 1'b1};

    PRESETn       = 1'b0;
    ifc.cmd_valid = 1'b0;
    ifc.cmd_write = 1'b0;
    ifc.cmd_addr  = '0;
    ifc.cmd_wdata = '0;
    ifc.PRDATA    = '0;
    ifc.PREADY    = 1'b1;
    ifc.PSLAVEERR = 1'b0;
    repeat (3) @(negedge PCLK);
    PRESETn = 1'b1;

    // Reset then idle
    for (int i = 0; i < 5; i++) begin
      @(negedge PCLK);
      chk("reset_ctrl",
          {ifc.PSEL, ifc.PENABLE, ifc.PWRITE, ifc.rsp_valid, ifc.rsp_err,
           ifc.rsp_timeout, ifc.busy, ifc.cmd_ready, state_dbg},
          {7'b0, 1'b1, 2'b00});
    end
    chk("reset_paddr", ifc.PADDR, 0);
    chk("reset_pwdata", ifc.PWDATA, 0);
    chk("reset_rdata", ifc.rsp_rdata, 0);

    // PWM programming burst, zero-wait slave
    for (int i = 0; i < 4; i++) begin
      chk("burst_ready", ifc.cmd_ready, 1);
      drive_cmd(1'b1, b_addr[i], b_data[i]);
      exp_q.push_back(rsp(1'b0, 1'b0, '0));
      @(negedge PCLK);
      if (i == 0) chk("burst_psel_n", ifc.PSEL, 0);
      if (i == 1) chk("burst_setup0", {ifc.PSEL, ifc.PENABLE, ifc.PADDR}, {2'b10, b_addr[0]});
      if (i == 2) chk("burst_access0", {ifc.PSEL, ifc.PENABLE}, 2'b11);
    end
    ifc.cmd_valid = 1'b0;
    for (int k = 1; k < 4; k++) begin
      chk("b2b_setup", {ifc.PSEL, ifc.PENABLE, ifc.PWRITE, ifc.rsp_valid},
          4'b1011);
      chk("b2b_addr", ifc.PADDR, b_addr[k]);
      chk("b2b_wdata", ifc.PWDATA, b_data[k]);
      @(negedge PCLK);
      chk("b2b_access", {ifc.PSEL, ifc.PENABLE, ifc.rsp_valid}, 3'b110);
      @(negedge PCLK);
    end
    chk("burst_end", {ifc.PSEL, ifc.rsp_valid, state_dbg}, 4'b0100);
    wait_idle();

    // Read with three wait states
    ifc.PREADY = 1'b0;
    ifc.PRDATA = 32'hDEAD;
    drive_cmd(1'b0, 32'h0, 32'h0);
    exp_q.push_back(rsp(1'b0, 1'b0, 32'd8));
    @(negedge PCLK);
    ifc.cmd_valid = 1'b0;
    @(negedge PCLK);
    chk("rd_setup", state_dbg, 1);
    @(negedge PCLK);
    chk("rd_access", {state_dbg, ifc.PENABLE}, 3'b101);
    for (int i = 0; i < 3; i++) begin
      @(negedge PCLK);
      chk("rd_wait", {state_dbg, ifc.rsp_valid}, 3'b100);
    end
    ifc.PREADY = 1'b1;
    ifc.PRDATA = 32'd8;
    @(negedge PCLK);
    chk("rd_done", {ifc.rsp_valid, state_dbg}, 3'b100);
    ifc.PRDATA = '0;
    wait_idle();

    // FIFO full while a transfer stalls, then timeout abort
    ifc.PREADY = 1'b0;
    ifc.PRDATA = 32'h5A5A;
    drive_cmd(1'b1, 32'h20, 32'h11);
    exp_q.push_back(rsp(1'b1, 1'b1, '0));
    @(negedge PCLK);
    for (int i = 0; i < 4; i++) begin
      chk("full_fill_ready", ifc.cmd_ready, 1);
      drive_cmd(f_wr[i], f_addr[i], 32'h100 + i);
      exp_q.push_back(rsp(1'b0, 1'b0, f_wr[i] ? '0 : 32'h5A5A));
      @(negedge PCLK);
    end
    chk("full_ready_low", ifc.cmd_ready, 0);
    drive_cmd(1'b1, 32'h34, 32'h66);
    repeat (13) @(negedge PCLK);
    chk("full_held", {ifc.cmd_ready, state_dbg, ifc.rsp_valid}, 4'b0100);
    @(negedge PCLK);
    chk("timeout_abort", {ifc.rsp_valid, state_dbg, ifc.PSEL, ifc.PENABLE}, 5'b10110);
    chk("timeout_next_addr", ifc.PADDR, 32'h24);
    chk("full_ready_back", ifc.cmd_ready, 1);
    exp_q.push_back(rsp(1'b0, 1'b0, '0));
    ifc.PREADY = 1'b1;
    @(negedge PCLK);
    ifc.cmd_valid = 1'b0;
    wait_idle();

    // Slave error
    ifc.PSLAVEERR = 1'b1;
    drive_cmd(1'b1, 32'h40, 32'h1);
    exp_q.push_back(rsp(1'b0, 1'b1, '0));
    @(negedge PCLK);
    ifc.cmd_valid = 1'b0;
    wait_idle();
    ifc.PSLAVEERR = 1'b0;

    // Reset mid-ACCESS with two commands queued
    ifc.PREADY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_cmd(1'b1, 32'h50 + 4 * i, 32'h200 + i);
      @(negedge PCLK);
    end
    ifc.cmd_valid = 1'b0;
    chk("rst_in_access", state_dbg, 2);
    #2 PRESETn = 1'b0;
    #1 chk("rst_async", {ifc.PSEL, ifc.PENABLE, ifc.busy}, 3'b000);
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b1;
    ifc.PREADY = 1'b1;
    repeat (3) begin
      @(negedge PCLK);
      chk("rst_after", {ifc.busy, ifc.rsp_valid, ifc.cmd_ready, ifc.PSEL}, 4'b0010);
    end

    chk("queue_empty", exp_q.size(), 0);
    chk("rsp_total", rsp_cnt, 12);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
